// File: rtl/perf_cache_counter.sv
// ---------------------------------------------------------------------------
// perf_cache_counter
//
// Collector for cache performance events. Every cycle a cache may present
// one event as an (id, access_type) pair. The block keeps one saturating
// counter per (id, access_type) pair plus a drop counter for events whose
// address falls outside the tracked range. A debug/host master reads the
// counters back through a valid/ready request/response port.
//
// Parameters:
//   NUM_IDS    number of tracked cache ids (ids 0..NUM_IDS-1), 1..254
//   NUM_TYPES  number of tracked access types (0..NUM_TYPES-1), 1..255
//   CNT_WIDTH  counter width in bits, 2..64
//
// Ports:
//   clk            in   single clock, all state on posedge
//   rst            in   synchronous active-high reset
//   valid          in   event strobe, at most one event per cycle
//   id             in   cache id of the event
//   access_type    in   access type of the event
//   clr            in   zero every counter, including the drop counter
//   rd_req_valid   in   read request valid
//   rd_req_ready   out  high while no response is pending
//   rd_req_id      in   id to read; 8'hFF selects the drop counter
//   rd_req_type    in   access type to read (ignored for the drop counter)
//   rd_req_clear   in   zero the addressed counter after reading it
//   rd_resp_valid  out  response valid
//   rd_resp_ready  in   response consumed when high with rd_resp_valid
//   rd_resp_data   out  counter value captured at request accept
//   rd_resp_hit    out  1 when the read address was in range or the drop
//                       counter; 0 means rd_resp_data is 0
// ---------------------------------------------------------------------------
module perf_cache_counter #(
    parameter int NUM_IDS   = 4,
    parameter int NUM_TYPES = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [7:0]           id,
    input  logic [7:0]           access_type,
    input  logic                 clr,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [7:0]           rd_req_id,
    input  logic [7:0]           rd_req_type,
    input  logic                 rd_req_clear,
    output logic                 rd_resp_valid,
    input  logic                 rd_resp_ready,
    output logic [CNT_WIDTH-1:0] rd_resp_data,
    output logic                 rd_resp_hit
);

    localparam int NUM_CNT = NUM_IDS * NUM_TYPES;

    localparam logic [7:0]           DROP_ID     = 8'hFF;
    localparam logic [7:0]           NUM_IDS_B   = 8'(NUM_IDS);
    localparam logic [7:0]           NUM_TYPES_B = 8'(NUM_TYPES);
    localparam logic [15:0]          NUM_TYPES_W = 16'(NUM_TYPES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_CNT];
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic [CNT_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic                   resp_hit_q, resp_hit_d;

    // -----------------------------------------------------------------------
    // Event decode
    // -----------------------------------------------------------------------
    logic        ev_in_range;
    logic        ev_drop;
    logic [15:0] ev_idx;

    // 16 bits covers the largest flat index (253*255+254).
    assign ev_in_range = valid && (id < NUM_IDS_B) && (access_type < NUM_TYPES_B);
    assign ev_drop     = valid && !ev_in_range;
    assign ev_idx      = 16'(id) * NUM_TYPES_W + 16'(access_type);

    // -----------------------------------------------------------------------
    // Read decode
    // -----------------------------------------------------------------------
    logic                 rd_in_range;
    logic                 rd_is_drop;
    logic [15:0]          rd_idx;
    logic                 rd_accept;
    logic                 rd_clr_cnt;
    logic                 rd_clr_drop;
    logic [CNT_WIDTH-1:0] rd_val;

    // NUM_IDS never exceeds 254, so 8'hFF can never alias a tracked id.
    assign rd_in_range = (rd_req_id < NUM_IDS_B) && (rd_req_type < NUM_TYPES_B);
    assign rd_is_drop  = (rd_req_id == DROP_ID);
    assign rd_idx      = 16'(rd_req_id) * NUM_TYPES_W + 16'(rd_req_type);
    assign rd_accept   = (state_q == ST_IDLE) && rd_req_valid;
    // An out-of-range read clears nothing.
    assign rd_clr_cnt  = rd_accept && rd_req_clear && rd_in_range;
    assign rd_clr_drop = rd_accept && rd_req_clear && rd_is_drop;

    // Read mux works on the registered counters, so the value returned is
    // the snapshot before any increment landing on the same edge.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a
        // default first; any path that skips an assignment infers a latch.
        rd_val = '0;
        if (rd_is_drop) begin
            rd_val = drop_q;
        end else if (rd_in_range) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (rd_idx == 16'(i)) begin
                    rd_val = cnt_q[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counter next state
    //
    // Order of effects at one edge: global clr wins outright and swallows a
    // same-cycle event. Otherwise a read-with-clear zeroes first and the
    // event increments afterwards, so clear+event on one counter leaves 1.
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else begin
                if (rd_clr_cnt && (rd_idx == 16'(i))) begin
                    cnt_d[i] = '0;
                end
                if (ev_in_range && (ev_idx == 16'(i)) && (cnt_d[i] != CNT_MAX)) begin
                    cnt_d[i] = cnt_d[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (clr) begin
            drop_d = '0;
        end else begin
            if (rd_clr_drop) begin
                drop_d = '0;
            end
            if (ev_drop && (drop_d != CNT_MAX)) begin
                drop_d = drop_d + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of all the others.
        if (rst) begin
            // NOTE: the counter array is reset explicitly because a reset
            // must leave every total at zero; storage without that need
            // would be left unreset.
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            drop_q <= drop_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state. RESP always returns to IDLE before another
    // request can be taken, which caps throughput at one read per two cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rd_req_valid)  state_d = ST_RESP;
            ST_RESP: if (rd_resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM: outputs, a pure function of state.
    always_comb begin
        rd_req_ready  = 1'b0;
        rd_resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: rd_req_ready  = 1'b1;
            ST_RESP: rd_resp_valid = 1'b1;
            default: rd_req_ready  = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Response register: loaded only on accept, then held through RESP so
    // later events and clears cannot disturb the value in flight.
    // -----------------------------------------------------------------------
    always_comb begin
        resp_data_d = resp_data_q;
        resp_hit_d  = resp_hit_q;
        if (rd_accept) begin
            resp_data_d = rd_val;
            resp_hit_d  = rd_in_range || rd_is_drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
        end else begin
            resp_data_q <= resp_data_d;
            resp_hit_q  <= resp_hit_d;
        end
    end

    assign rd_resp_data = resp_data_q;
    assign rd_resp_hit  = resp_hit_q;

endmodule
